win3x3_gen: RTL and testbench
=============================

// Module: win3x3_gen
// PURPOSE
//  - 3x3 neighbourhood generator in front of the 3x3 weighted-mask convolution stages.
//  - Accepts a raster pixel stream of 16-bit words: [15:4] = 12-bit data, [3:0] = Bayer/state tag.
//  - Buffers two lines and emits, per accepted pixel, the 9-pixel window centred one row and one
//    column behind it, on the ports the mask stage consumes (centre, 4 cross, 4 diagonal) plus win_valid.
// PARAMETERS
//  IMG_WIDTH   640  active pixels per line (>=3); sets line-buffer depth
//  IMG_HEIGHT  480  active lines per frame (>=3)
//  PIX_W       16   pixel word width, tag included; passed through unmodified
// PORTS
//  isp_clk    in   1      pixel clock
//  rst        in   1      synchronous reset, active-high
//  din        in   PIX_W  input pixel, raster order
//  din_valid  in   1      din is valid this cycle
//  din_sof    in   1      qualified by din_valid: din is pixel (0,0) of a new frame
//  din_ready  out  1      stage can accept din (see CONFIGURATION)
//  dout_ready in   1      downstream can accept window (see CONFIGURATION)
//  win_c      out  PIX_W  centre (r-1,c-1)                   -> 4x weight
//  win_n/w/e/s out PIX_W  (r-2,c-1),(r-1,c-2),(r-1,c),(r,c-1) -> 2x weights 1..4
//  win_nw/ne/sw/se out PIX_W (r-2,c-2),(r-2,c),(r,c-2),(r,c)  -> 1x weights 1..4
//  win_valid  out  1      window outputs are valid
// BEHAVIOUR
//  - Accept = din_valid & din_ready. Column/row counters (col, row) refer to the accepted pixel.
//  - Counters: col++ per accept; at col==IMG_WIDTH-1 col->0, row++; at last pixel of frame
//    (row==IMG_HEIGHT-1, col==IMG_WIDTH-1) both wrap to 0.
//  - din_sof on an accept forces that pixel to (0,0) regardless of counter state (mid-frame restart);
//    line-buffer contents are not cleared, prior-frame data is masked by the valid rule.
//  - Line buffers LB0 (row r-1), LB1 (row r-2): IMG_WIDTH deep each, read-before-write at index col;
//    on accept: LB1[col]<=LB0[col], LB0[col]<=din.
//  - Window regs: 3x3 shift array; on accept columns shift left, new right column = {LB1[col],LB0[col],din}.
//  - Latency: window for accept at cycle t is on outputs at t+1.
//  - win_valid <= accept & (row>=2) & (col>=2). Per frame exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
//  - No border synthesis: centres on row 0, last row, col 0, last col produce no window.
//  - Column shift continues across line ends; windows with col<2 are suppressed, so no wrap pixels leak.
//  - Pixels arrive with arbitrary gaps; no accept -> win_valid<=0, window regs hold.
//  - Reset: col=row=0, all win_* = 0, win_valid=0; line-buffer RAM not reset.
//  - Reset mid-frame: next accepted pixel treated as (0,0) whether or not din_sof is set.
//  - No arithmetic on pixel data; tag bits [3:0] travel with each pixel.
// CONFIGURATION
//  - WIN3X3_BACKPRESSURE_EN defined:
//      din_ready = dout_ready | ~win_valid.
//      While win_valid & ~dout_ready: all win_* outputs, win_valid, counters, LB and window regs hold.
//  - Not defined:
//      din_ready tied 1, dout_ready ignored.
//      win_valid is a 1-cycle pulse per window.
// TESTING
//  - IMG_WIDTH=8, IMG_HEIGHT=6, din={row[5:0],col[5:0],4'hA}, continuous valid:
//    first win_valid one cycle after pixel (2,2); win_c=(1,1), win_se=(2,2), win_nw=(0,0),
//    all tags 4'hA; 24 windows per frame.
//  - Same frame with random 0-3 cycle gaps on din_valid: identical window sequence, 24 windows,
//    win_valid never asserted in a gap cycle.
//  - Line boundary: accept (3,7), then (4,0),(4,1) -> window centre (2,6) emitted;
//    nothing for (4,0)/(4,1); next window at (4,2) with win_w=(3,0).
//  - din_sof at pixel 20 of frame: counters restart, no window until new (2,2);
//    window count restarts and reaches 24 for the new frame.
//  - rst pulsed while row=3: all outputs 0 next cycle; stream restarted at (0,0) behaves as the first test.
//  - WIN3X3_BACKPRESSURE_EN: hold dout_ready=0 for 5 cycles with window pending:
//    win_* stable, din_ready=0, no pixel lost; sequence matches the first test.

Source files
------------

// File: rtl/win3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
// Optional output backpressure is enabled by defining WIN3X3_BACKPRESSURE_EN.
module win3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 16
) (
  input  logic             isp_clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_sof,
  output logic             din_ready,
  input  logic             dout_ready,
  output logic [PIX_W-1:0] win_c,
  output logic [PIX_W-1:0] win_n,
  output logic [PIX_W-1:0] win_w,
  output logic [PIX_W-1:0] win_e,
  output logic [PIX_W-1:0] win_s,
  output logic [PIX_W-1:0] win_nw,
  output logic [PIX_W-1:0] win_ne,
  output logic [PIX_W-1:0] win_sw,
  output logic [PIX_W-1:0] win_se,
  output logic             win_valid
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_valid;
  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_win [3][3];

  logic             w_acc;
  logic             w_stall;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;
  logic             w_win_ok;

`ifdef WIN3X3_BACKPRESSURE_EN
  assign w_stall = r_valid & ~dout_ready;
`else
  logic w_unused_dout_ready;
  assign w_unused_dout_ready = dout_ready;
  assign w_stall = 1'b0;
`endif

  assign din_ready = ~w_stall;
  assign w_acc     = din_valid & din_ready;

  // sof forces the accepted pixel to (0,0) whatever the counters say
  assign w_col = din_sof ? '0 : r_col;
  assign w_row = din_sof ? '0 : r_row;

  assign w_lb0_rd = r_lb0[w_col];
  assign w_lb1_rd = r_lb1[w_col];

  assign w_win_ok = (w_row >= ROW_TWO) & (w_col >= COL_TWO);

  always_ff @(posedge isp_clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        if (w_row == ROW_LAST) begin
          r_row <= '0;
        end else begin
          r_row <= w_row + RW'(1);
        end
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // line RAMs: no reset, stale data is masked by the window valid rule
  always_ff @(posedge isp_clk) begin
    if (w_acc) begin
      r_lb1[w_col] <= w_lb0_rd;
      r_lb0[w_col] <= din;
    end
  end

  always_ff @(posedge isp_clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_lb1_rd;
      r_win[1][2] <= w_lb0_rd;
      r_win[2][2] <= din;
    end
  end

  always_ff @(posedge isp_clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_valid <= w_acc & w_win_ok;
    end
  end

  assign win_nw    = r_win[0][0];
  assign win_n     = r_win[0][1];
  assign win_ne    = r_win[0][2];
  assign win_w     = r_win[1][0];
  assign win_c     = r_win[1][1];
  assign win_e     = r_win[1][2];
  assign win_sw    = r_win[2][0];
  assign win_s     = r_win[2][1];
  assign win_se    = r_win[2][2];
  assign win_valid = r_valid;

endmodule

// File: tb/tb_win3x3_gen.sv
// Bench for win3x3_gen on an 8x6 frame against a frame-array reference.
// Covers streaming, gaps, line wrap, sof restart, reset and backpressure.
module tb_win3x3_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 16;

  logic          isp_clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_sof = 1'b0;
  logic          din_ready;
  logic          dout_ready = 1'b1;
  logic [PW-1:0] win_c, win_n, win_w, win_e, win_s;
  logic [PW-1:0] win_nw, win_ne, win_sw, win_se;
  logic          win_valid;

  logic [PW-1:0] img [H][W];
  int n_run  = 0;
  int n_fail = 0;

  wire [9*PW-1:0] obs = {win_nw, win_n, win_ne, win_w, win_c,
                         win_e, win_sw, win_s, win_se};

  win3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .isp_clk(isp_clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_sof(din_sof), .din_ready(din_ready), .dout_ready(dout_ready),
    .win_c(win_c), .win_n(win_n), .win_w(win_w), .win_e(win_e),
    .win_s(win_s), .win_nw(win_nw), .win_ne(win_ne), .win_sw(win_sw),
    .win_se(win_se), .win_valid(win_valid)
  );

  always #5 isp_clk = ~isp_clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // window centred at (r-1,c-1) for the pixel accepted at (r,c)
  function automatic logic [9*PW-1:0] exp_win(int r, int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  task automatic new_img(input bit pattern);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (pattern)
          img[y][x] = {6'(y), 6'(x), 4'hA};
        else
          img[y][x] = 16'($urandom);
  endtask

  task automatic drv(input logic [PW-1:0] d, input logic sof);
    din = d;
    din_valid = 1'b1;
    din_sof = sof;
    @(posedge isp_clk);
    #1;
    din_valid = 1'b0;
    din_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge isp_clk);
    #1;
    n_run++;
    if (win_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got %b exp 0", win_valid);
    end
    n_run++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL rst_win got %h exp 0", obs);
    end
    n_run++;
    if (din_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got %b exp 1", din_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int nwin = 0;
    new_img(1'b1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drv(img[r][c], (r == 0 && c == 0));
        n_run++;
        if (win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("FAIL cont_valid r=%0d c=%0d got %b", r, c, win_valid);
        end
        if (r >= 2 && c >= 2) begin
          n_run++;
          if (obs !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL cont_win r=%0d c=%0d got %h exp %h",
                     r, c, obs, exp_win(r, c));
          end
        end
        if (win_valid === 1'b1) nwin++;
      end
    n_run++;
    if (nwin != 24) begin
      n_fail++; $display("FAIL cont_count got %0d exp 24", nwin);
    end
  endtask

  task automatic test_gaps();
    int nwin = 0;
    new_img(1'b1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        repeat ($urandom_range(0, 3)) begin
`ifndef WIN3X3_BACKPRESSURE_EN
          dout_ready = 1'($urandom);
`endif
          @(posedge isp_clk);
          #1;
          n_run++;
          if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_valid r=%0d c=%0d got %b exp 0", r, c, win_valid);
          end
        end
        drv(img[r][c], (r == 0 && c == 0));
        n_run++;
        if (win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("FAIL gap_pix_valid r=%0d c=%0d got %b", r, c, win_valid);
        end
        if (r >= 2 && c >= 2) begin
          n_run++;
          if (obs !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL gap_win r=%0d c=%0d got %h exp %h",
                     r, c, obs, exp_win(r, c));
          end
        end
        if (win_valid === 1'b1) nwin++;
      end
    dout_ready = 1'b1;
    n_run++;
    if (nwin != 24) begin
      n_fail++; $display("FAIL gap_count got %0d exp 24", nwin);
    end
  endtask

  task automatic test_line_boundary();
    new_img(1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        drv(img[r][c], (r == 0 && c == 0));
    n_run++;
    if (win_valid !== 1'b1 || win_c !== img[2][6]) begin
      n_fail++;
      $display("FAIL lb_end got v=%b c=%h exp v=1 c=%h", win_valid, win_c, img[2][6]);
    end
    n_run++;
    if (obs !== exp_win(3, 7)) begin
      n_fail++; $display("FAIL lb_end_win got %h exp %h", obs, exp_win(3, 7));
    end
    for (int c = 0; c < 2; c++) begin
      drv(img[4][c], 1'b0);
      n_run++;
      if (win_valid !== 1'b0) begin
        n_fail++; $display("FAIL lb_wrap c=%0d got %b exp 0", c, win_valid);
      end
    end
    drv(img[4][2], 1'b0);
    n_run++;
    if (win_valid !== 1'b1 || win_w !== img[3][0]) begin
      n_fail++;
      $display("FAIL lb_next got v=%b w=%h exp v=1 w=%h", win_valid, win_w, img[3][0]);
    end
  endtask

  task automatic test_sof_restart();
    int nwin = 0;
    new_img(1'b0);
    for (int p = 0; p < 20; p++) begin
      drv(img[p / W][p % W], (p == 0));
      n_run++;
      if (win_valid !== (p / W >= 2 && p % W >= 2)) begin
        n_fail++; $display("FAIL sofA_valid p=%0d got %b", p, win_valid);
      end
    end
    new_img(1'b0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drv(img[r][c], (r == 0 && c == 0));
        n_run++;
        if (win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("FAIL sof_valid r=%0d c=%0d got %b", r, c, win_valid);
        end
        if (r >= 2 && c >= 2) begin
          n_run++;
          if (obs !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL sof_win r=%0d c=%0d got %h exp %h",
                     r, c, obs, exp_win(r, c));
          end
        end
        if (win_valid === 1'b1) nwin++;
      end
    n_run++;
    if (nwin != 24) begin
      n_fail++; $display("FAIL sof_count got %0d exp 24", nwin);
    end
  endtask

  task automatic test_reset_midframe();
    int nwin = 0;
    new_img(1'b0);
    for (int p = 0; p < 3 * W + 3; p++)
      drv(img[p / W][p % W], (p == 0));
    rst = 1'b1;
    @(posedge isp_clk);
    #1;
    rst = 1'b0;
    n_run++;
    if (win_valid !== 1'b0 || obs !== '0) begin
      n_fail++; $display("FAIL mrst_out got v=%b win=%h exp 0", win_valid, obs);
    end
    n_run++;
    if (din_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_ready got %b exp 1", din_ready);
    end
    new_img(1'b1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drv(img[r][c], 1'b0);
        n_run++;
        if (win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("FAIL mrst_valid r=%0d c=%0d got %b", r, c, win_valid);
        end
        if (r >= 2 && c >= 2) begin
          n_run++;
          if (obs !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL mrst_win r=%0d c=%0d got %h exp %h",
                     r, c, obs, exp_win(r, c));
          end
        end
        if (win_valid === 1'b1) nwin++;
      end
    n_run++;
    if (nwin != 24) begin
      n_fail++; $display("FAIL mrst_count got %0d exp 24", nwin);
    end
  endtask

`ifdef WIN3X3_BACKPRESSURE_EN
  task automatic test_backpressure();
    int nwin = 0;
    new_img(1'b0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 3 && c == 4) begin
          dout_ready = 1'b0;
          din = img[r][c];
          din_valid = 1'b1;
          repeat (5) begin
            @(posedge isp_clk);
            #1;
            n_run++;
            if (din_ready !== 1'b0 || win_valid !== 1'b1) begin
              n_fail++;
              $display("FAIL bp_hold got rdy=%b v=%b exp rdy=0 v=1", din_ready, win_valid);
            end
            n_run++;
            if (obs !== exp_win(3, 3)) begin
              n_fail++; $display("FAIL bp_stable got %h exp %h", obs, exp_win(3, 3));
            end
          end
          dout_ready = 1'b1;
          @(posedge isp_clk);
          #1;
          din_valid = 1'b0;
        end else begin
          drv(img[r][c], (r == 0 && c == 0));
        end
        n_run++;
        if (win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("FAIL bp_valid r=%0d c=%0d got %b", r, c, win_valid);
        end
        if (r >= 2 && c >= 2) begin
          n_run++;
          if (obs !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL bp_win r=%0d c=%0d got %h exp %h",
                     r, c, obs, exp_win(r, c));
          end
        end
        if (win_valid === 1'b1) nwin++;
      end
    n_run++;
    if (nwin != 24) begin
      n_fail++; $display("FAIL bp_count got %0d exp 24", nwin);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_line_boundary();
    test_sof_restart();
    test_reset_midframe();
`ifdef WIN3X3_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
